// File: rtl/edge_pulse_counter.sv
// Counts edges in a burst. A burst closes after GAP_CYCLES idle cycles, and its
// result is held until the consumer accepts it. Edges that arrive while a result is held are counted as drops.
module edge_pulse_counter #(
  parameter int CNT_W      = 8,
  parameter int GAP_W      = 16,
  parameter int GAP_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             edgeFlag,
  output logic [CNT_W-1:0] countOut,
  output logic             overflow,
  output logic             countValid,
  input  logic             countReady,
  output logic [CNT_W-1:0] dropCount,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [GAP_W-1:0] gap_r, gap_nxt_s;
  logic             ovf_bit_r, ovf_bit_nxt_s;
  logic [CNT_W-1:0] count_out_r, count_out_nxt_s;
  logic             overflow_r, overflow_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic [CNT_W-1:0] drop_r, drop_nxt_s;
  logic             busy_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Next-state and next-output logic for the burst FSM
  always_comb begin
    state_nxt_s     = state_r;
    count_nxt_s     = count_r;
    gap_nxt_s       = gap_r;
    ovf_bit_nxt_s   = ovf_bit_r;
    count_out_nxt_s = count_out_r;
    overflow_nxt_s  = overflow_r;
    valid_nxt_s     = valid_r;
    drop_nxt_s      = drop_r;
    case (state_r)
      ST_IDLE: begin
        if (edgeFlag) begin
          count_nxt_s   = CNT_ONE;
          gap_nxt_s     = GAP_ZERO;
          ovf_bit_nxt_s = 1'b0;
          state_nxt_s   = ST_COUNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (edgeFlag) begin
          // An edge on the last gap cycle still extends the burst
          if (count_r == CNT_MAX) begin
            ovf_bit_nxt_s = 1'b1;
          end else begin
            count_nxt_s = count_r + CNT_ONE;
          end
          gap_nxt_s = GAP_ZERO;
        end else if (gap_r == GAP_LAST) begin
          count_out_nxt_s = count_r;
          overflow_nxt_s  = ovf_bit_r;
          valid_nxt_s     = 1'b1;
          state_nxt_s     = ST_HOLD;
        end else begin
          gap_nxt_s = gap_r + GAP_ONE;
        end
      end
      ST_HOLD: begin
        if (edgeFlag) begin
          drop_nxt_s = sat_inc(drop_r);
        end else begin
          drop_nxt_s = drop_r;
        end
        if (countReady) begin
          valid_nxt_s   = 1'b0;
          count_nxt_s   = CNT_ZERO;
          gap_nxt_s     = GAP_ZERO;
          ovf_bit_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any open or held burst
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      count_r     <= CNT_ZERO;
      gap_r       <= GAP_ZERO;
      ovf_bit_r   <= 1'b0;
      count_out_r <= CNT_ZERO;
      overflow_r  <= 1'b0;
      valid_r     <= 1'b0;
      drop_r      <= CNT_ZERO;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      gap_r       <= gap_nxt_s;
      ovf_bit_r   <= ovf_bit_nxt_s;
      count_out_r <= count_out_nxt_s;
      overflow_r  <= overflow_nxt_s;
      valid_r     <= valid_nxt_s;
      drop_r      <= drop_nxt_s;
      busy_r      <= (state_nxt_s == ST_COUNT);
    end
  end

  assign countOut   = count_out_r;
  assign overflow   = overflow_r;
  assign countValid = valid_r;
  assign dropCount  = drop_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_edge_pulse_counter.sv
// Randomized and directed bench for edge_pulse_counter against a
// cycle-level reference model built from burst/gap rules.
module tb_edge_pulse_counter;

  localparam int CNT_W = 8;
  localparam int GAP_W = 16;
  localparam int GAP   = 8;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             edgeFlag = 1'b0;
  logic             countReady = 1'b0;
  logic [CNT_W-1:0] countOut;
  logic             overflow;
  logic             countValid;
  logic [CNT_W-1:0] dropCount;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 idle, 1 collecting, 2 result pending
  int m_mode, m_edges, m_quiet, m_out, m_ovf, m_valid, m_drop;

  edge_pulse_counter #(.CNT_W(CNT_W), .GAP_W(GAP_W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .edgeFlag(edgeFlag), .countOut(countOut),
    .overflow(overflow), .countValid(countValid), .countReady(countReady),
    .dropCount(dropCount), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_edges = 0; m_quiet = 0;
    m_out = 0; m_ovf = 0; m_valid = 0; m_drop = 0;
  endfunction

  function automatic void model_clock(input logic e, input logic r);
    case (m_mode)
      0: if (e) begin m_mode = 1; m_edges = 1; m_quiet = 0; end
      1: begin
        if (e) begin
          m_edges++; m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet == GAP) begin
            m_out = (m_edges > CMAX) ? CMAX : m_edges;
            m_ovf = (m_edges > CMAX) ? 1 : 0;
            m_valid = 1; m_mode = 2;
          end
        end
      end
      default: begin
        if (e && m_drop < CMAX) m_drop++;
        if (r) begin m_valid = 0; m_mode = 0; end
      end
    endcase
  endfunction

  function automatic logic [18:0] act_vec();
    return {countOut, overflow, countValid, dropCount, busy};
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [7:0] o, d;
    o = 8'(m_out); d = 8'(m_drop);
    return {o, (m_ovf != 0), (m_valid != 0), d, (m_mode == 1)};
  endfunction

  task automatic step(input logic e, input logic r);
    edgeFlag = e; countReady = r;
    @(posedge clk);
    model_clock(e, r);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; edgeFlag = 1'b0; countReady = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_vec() !== 19'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", act_vec());
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int first, pulses;
    logic [7:0] seen;
    first = -1; pulses = 0; seen = 8'd0;
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 1; k <= GAP + 4; k++) begin
      step(1'b0, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL basic_cycle k=%0d: got %h expected %h", k, act_vec(), exp_vec());
      end
      if (countValid) begin
        pulses++; seen = countOut;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first != GAP || pulses != 1 || seen !== 8'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: latency %0d pulses %0d count %0d expected latency %0d pulses 1 count 3",
               first, pulses, seen, GAP);
    end
  endtask

  task automatic test_gap_boundary();
    int bursts;
    logic [7:0] last;
    for (int pass = 0; pass < 2; pass++) begin
      bursts = 0; last = 8'd0;
      for (int n = 0; n < 5; n++) begin
        step(1'b1, 1'b1);
        for (int q = 0; q < ((pass == 0) ? 7 : 9); q++) begin
          step(1'b0, 1'b1);
          if (countValid) begin bursts++; last = countOut; end
        end
      end
      for (int q = 0; q < GAP + 2; q++) begin
        step(1'b0, 1'b1);
        if (countValid) begin bursts++; last = countOut; end
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL gap_model pass=%0d: got %h expected %h", pass, act_vec(), exp_vec());
      end
      checks++;
      if (pass == 0 && (bursts != 1 || last !== 8'd5)) begin
        errors++; $display("FAIL gap_7: bursts %0d count %0d expected 1 burst count 5", bursts, last);
      end else if (pass == 1 && (bursts != 5 || last !== 8'd1)) begin
        errors++; $display("FAIL gap_9: bursts %0d count %0d expected 5 bursts count 1", bursts, last);
      end
    end
  endtask

  task automatic test_overflow();
    for (int b = 0; b < 2; b++) begin
      repeat ((b == 0) ? 300 : 1) step(1'b1, 1'b0);
      for (int q = 0; q < GAP && !countValid; q++) step(1'b0, 1'b0);
      checks++;
      if (!countValid) begin
        errors++; $display("FAIL ovf_timeout burst=%0d: countValid 0 expected 1", b);
      end
      checks++;
      if (b == 0 && (countOut !== 8'd255 || overflow !== 1'b1)) begin
        errors++; $display("FAIL ovf_big: count %0d ovf %b expected 255 1", countOut, overflow);
      end else if (b == 1 && (countOut !== 8'd1 || overflow !== 1'b0)) begin
        errors++; $display("FAIL ovf_small: count %0d ovf %b expected 1 0", countOut, overflow);
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovf_model: got %h expected %h", act_vec(), exp_vec());
      end
      step(1'b0, 1'b1);
    end
  endtask

  task automatic test_hold();
    logic [7:0] held, drop0;
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    for (int q = 0; q < GAP && !countValid; q++) step(1'b0, 1'b0);
    held = countOut; drop0 = dropCount;
    for (int i = 0; i < 20; i++) begin
      step((i % 5) == 2, 1'b0);
      checks++;
      if (countValid !== 1'b1 || countOut !== held || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL hold_stable i=%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (dropCount !== drop0 + 8'd4 || held !== 8'd2) begin
      errors++; $display("FAIL hold_drop: drop %0d count %0d expected %0d 2", dropCount, held, drop0 + 8'd4);
    end
    step(1'b0, 1'b1);
    checks++;
    if (countValid !== 1'b0 || busy !== 1'b0 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL hold_accept: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_handshake_edge();
    logic [7:0] drop0;
    step(1'b1, 1'b0);
    for (int q = 0; q < GAP && !countValid; q++) step(1'b0, 1'b0);
    drop0 = dropCount;
    step(1'b1, 1'b1);
    checks++;
    if (dropCount !== drop0 + 8'd1 || countValid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hs_edge: drop %0d valid %b busy %b expected %0d 0 0",
                         dropCount, countValid, busy, drop0 + 8'd1);
    end
    step(1'b1, 1'b1);
    for (int q = 0; q < GAP && !countValid; q++) step(1'b0, 1'b1);
    checks++;
    if (countValid !== 1'b1 || countOut !== 8'd1) begin
      errors++; $display("FAIL hs_next: valid %b count %0d expected 1 1", countValid, countOut);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act_vec() !== 19'd0) begin
      errors++; $display("FAIL reset_mid: got %h expected 0", act_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      model_reset();
      if (countValid) pulses++;
    end
    reset = 1'b1;
    step(1'b1, 1'b1);
    for (int q = 0; q < GAP + 1 && !countValid; q++) step(1'b0, 1'b1);
    checks++;
    if (pulses != 0 || countValid !== 1'b1 || countOut !== 8'd1 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_after: pulses %0d valid %b count %0d expected 0 1 1",
                         pulses, countValid, countOut);
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic e, r;
    int mode_sel;
    for (int i = 0; i < 3000; i++) begin
      mode_sel = (i / 300) % 3;
      e = (mode_sel == 0) ? ($urandom_range(0, 9) < 2) :
          (mode_sel == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) == 0);
      step(e, r);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap_boundary();
    test_overflow();
    test_hold();
    test_handshake_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
